mult_arbiter: RTL
=================

MULT_ARBITER -- requirements
Module: mult_arbiter

Interface
REQ-001 The block SHALL have parameters: N_REQ, default 3, number of requesters; LANES, default 9, multiplier lanes; W, default 36, lane width in bits; LAT, default 4, fixed multiplier latency in cycles (LAT >= 1); LEN_W, default 4, burst-length field width.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state SHALL be clocked on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-004 The block SHALL have port req_valid, input, N_REQ bits: per-requester beat valid.
REQ-005 The block SHALL have port req_len, input, N_REQ x LEN_W bits: beats in the burst, sampled at grant, where 0 means 1.
REQ-006 The block SHALL have ports req_dataa and req_datab, input, N_REQ x LANES x W bits: per-requester operands.
REQ-007 The block SHALL have port req_ready, output, N_REQ bits: beat accepted this cycle.
REQ-008 The block SHALL have ports mult_dataa and mult_datab, output, LANES x W bits: operands to the shared multiplier.
REQ-009 The block SHALL have port mult_result, input, LANES x W bits: multiplier product, valid LAT cycles after its operands.
REQ-010 The block SHALL have port rsp_valid, output, N_REQ bits: one-hot result strobe.
REQ-011 The block SHALL have port rsp_result, output, LANES x W bits: shared result bus.
REQ-012 The block SHALL have port rsp_last, output, 1 bit: result is the final beat of its burst.
REQ-013 The block SHALL have port busy, output, 1 bit: burst active or any result in flight.

Function
REQ-014 The block SHALL implement a state machine with states IDLE and BURST, plus registers owner, beats_left (LEN_W bits), rr_ptr, and an LAT-deep tag pipe of {valid, id, last}.
REQ-015 In IDLE with any req_valid high, the block SHALL select the winner round-robin in order rr_ptr+1, rr_ptr+2, ..., rr_ptr (mod N_REQ), assert req_ready[winner] in the same cycle, and issue the winner's first beat in that cycle.
REQ-016 In the IDLE grant cycle, the block SHALL set owner to the winner, set rr_ptr to the winner, and set beats_left to max(req_len,1)-1; if that value is 0 it SHALL stay in IDLE, otherwise it SHALL enter BURST.
REQ-017 In BURST, req_ready[owner] SHALL equal req_valid[owner], and all other req_ready bits SHALL be 0.
REQ-018 In BURST, each issued beat SHALL decrement beats_left; the beat issued at beats_left==1 SHALL be last, and the state SHALL return to IDLE next cycle.
REQ-019 In BURST, a cycle with req_valid[owner] low SHALL be a bubble: no issue, no decrement, and the grant is held.
REQ-020 Back-to-back bursts SHALL have no idle cycle, because arbitration and issue occur in the same cycle in IDLE.
REQ-021 In an issue cycle, mult_dataa and mult_datab SHALL carry the owner's operands; in all other cycles they SHALL be all-zero.
REQ-022 Each issue SHALL push {1, id, last} into tag stage 0, and non-issue cycles SHALL push {0, -, 0}; the tag SHALL reach the final stage exactly LAT cycles after issue.
REQ-023 When the final tag stage is valid, the block SHALL, combinationally in that cycle, drive rsp_valid[id]=1, rsp_result=mult_result and rsp_last=tag.last; otherwise rsp_valid=0, rsp_result=0 and rsp_last=0.
REQ-024 Results SHALL be returned in issue order with exactly one rsp_valid pulse per accepted beat.
REQ-025 busy SHALL be 1 when state==BURST or any tag stage is valid.
REQ-026 A requester dropping req_valid mid-burst SHALL NOT release the grant; the grant is released only when beats_left reaches 0.

Reset
REQ-027 While rst is high, state SHALL be IDLE, beats_left=0, owner=0, rr_ptr=N_REQ-1 (so requester 0 has first priority), and all tag valids SHALL be 0.
REQ-028 While rst is high, the outputs SHALL be req_ready=0, mult_dataa/b=0, rsp_valid=0, rsp_result=0, rsp_last=0, busy=0.
REQ-029 Reset asserted mid-burst or with results in flight SHALL abort the burst and discard in-flight results; no rsp_valid SHALL follow for beats issued before reset.

Verification
REQ-030 Single beat: req_valid=001, req_len[0]=1, A=B=lanes of 2 -> req_ready=001 same cycle, rsp_valid=001 with rsp_last=1 exactly 4 cycles later, busy falling after.
REQ-031 Round-robin: req_valid=111 held, all len=1 -> grants in order 0,1,2,0 on consecutive cycles, with no bubbles.
REQ-032 Burst with gap: req 1, len=3, req_valid[1] low on the second cycle -> issues at t, t+2, t+3, req 0 blocked until t+4, rsp_last only on the third response.
REQ-033 len=0 -> treated as 1 beat, with no BURST entry.
REQ-034 Reset mid-flight: rst pulse 2 cycles after issuing 2 beats -> no rsp_valid afterward, and rr_ptr restored so requester 0 wins next.
REQ-035 Back-to-back: req 2 len=2, req 0 len=1 pending -> req 0 issued in the cycle immediately after req 2's last beat.

Source files
------------

// File: rtl/mult_arbiter_if.sv
// Bundle of requester, shared-multiplier and response signals for mult_arbiter.
// The slave modport is the arbiter's view; master is the requester/multiplier side.
interface mult_arbiter_if #(
    parameter int N_REQ = 3,
    parameter int LANES = 9,
    parameter int W     = 36,
    parameter int LEN_W = 4
);
    logic [N_REQ-1:0]                       req_valid;
    logic [N_REQ-1:0][LEN_W-1:0]            req_len;
    logic [N_REQ-1:0][LANES-1:0][W-1:0]     req_dataa;
    logic [N_REQ-1:0][LANES-1:0][W-1:0]     req_datab;
    logic [N_REQ-1:0]                       req_ready;
    logic [LANES-1:0][W-1:0]                mult_dataa;
    logic [LANES-1:0][W-1:0]                mult_datab;
    logic [LANES-1:0][W-1:0]                mult_result;
    logic [N_REQ-1:0]                       rsp_valid;
    logic [LANES-1:0][W-1:0]                rsp_result;
    logic                                   rsp_last;
    logic                                   busy;

    modport slave (
        input  req_valid, req_len, req_dataa, req_datab, mult_result,
        output req_ready, mult_dataa, mult_datab, rsp_valid, rsp_result, rsp_last, busy
    );

    modport master (
        output req_valid, req_len, req_dataa, req_datab, mult_result,
        input  req_ready, mult_dataa, mult_datab, rsp_valid, rsp_result, rsp_last, busy
    );
endinterface

// File: rtl/mult_arbiter.sv
// Round-robin burst arbiter sharing one LAT-cycle multiplier among N_REQ requesters.
// Grant and first beat issue in the same cycle; results return in issue order LAT cycles later.
module mult_arbiter #(
    parameter int N_REQ = 3,
    parameter int LANES = 9,
    parameter int W     = 36,
    parameter int LAT   = 4,
    parameter int LEN_W = 4
) (
    input  logic            clk,
    input  logic            rst,
    mult_arbiter_if.slave   bus
);
    localparam int ID_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    typedef logic [LANES-1:0][W-1:0] lanes_t;
    typedef enum logic {IDLE, BURST} state_t;

    state_t                     state_q;
    logic [ID_W-1:0]            owner_q;
    logic [ID_W-1:0]            rr_ptr_q;
    logic [LEN_W-1:0]           beats_left_q;
    logic [LAT-1:0]             tag_vld_q;
    logic [LAT-1:0][ID_W-1:0]   tag_id_q;
    logic [LAT-1:0]             tag_last_q;

    logic                       win_found;
    logic [ID_W-1:0]            win_id;
    logic [LEN_W-1:0]           len_sel;
    logic [LEN_W-1:0]           len_m1;
    logic                       issue;
    logic [ID_W-1:0]            issue_id;
    logic                       issue_last;
    lanes_t                     op_a;
    lanes_t                     op_b;

    // Search starts one past the last winner so every requester gets a turn.
    always_comb begin
        win_found = 1'b0;
        win_id    = '0;
        for (int i = 1; i <= N_REQ; i++) begin
            if (!win_found && bus.req_valid[(int'(rr_ptr_q) + i) % N_REQ]) begin
                win_found = 1'b1;
                win_id    = ID_W'((int'(rr_ptr_q) + i) % N_REQ);
            end
        end
    end

    always_comb begin
        len_sel    = bus.req_len[win_id];
        len_m1     = (len_sel == '0) ? '0 : len_sel - LEN_W'(1);
        issue      = 1'b0;
        issue_id   = owner_q;
        issue_last = 1'b0;
        if (!rst) begin
            if (state_q == IDLE) begin
                issue      = win_found;
                issue_id   = win_id;
                issue_last = (len_m1 == '0);
            end else begin
                issue      = bus.req_valid[owner_q];
                issue_id   = owner_q;
                issue_last = (beats_left_q == LEN_W'(1));
            end
        end
    end

    always_comb begin
        for (int r = 0; r < N_REQ; r++) begin
            bus.req_ready[r] = issue && (issue_id == ID_W'(r));
        end
        op_a = issue ? bus.req_dataa[issue_id] : '0;
        op_b = issue ? bus.req_datab[issue_id] : '0;
    end

    assign bus.mult_dataa = op_a;
    assign bus.mult_datab = op_b;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            owner_q      <= '0;
            beats_left_q <= '0;
            rr_ptr_q     <= ID_W'(N_REQ - 1);
            tag_vld_q    <= '0;
            tag_id_q     <= '0;
            tag_last_q   <= '0;
        end else begin
            tag_vld_q[0]  <= issue;
            tag_id_q[0]   <= issue_id;
            tag_last_q[0] <= issue && issue_last;
            for (int k = 1; k < LAT; k++) begin
                tag_vld_q[k]  <= tag_vld_q[k-1];
                tag_id_q[k]   <= tag_id_q[k-1];
                tag_last_q[k] <= tag_last_q[k-1];
            end
            case (state_q)
                IDLE: begin
                    if (issue) begin
                        owner_q      <= win_id;
                        rr_ptr_q     <= win_id;
                        beats_left_q <= len_m1;
                        state_q      <= (len_m1 == '0) ? IDLE : BURST;
                    end
                end
                BURST: begin
                    // A bubble (owner not valid) holds both the count and the grant.
                    if (issue) begin
                        beats_left_q <= beats_left_q - LEN_W'(1);
                        if (beats_left_q == LEN_W'(1)) begin
                            state_q <= IDLE;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    always_comb begin
        for (int r = 0; r < N_REQ; r++) begin
            bus.rsp_valid[r] = tag_vld_q[LAT-1] && (tag_id_q[LAT-1] == ID_W'(r));
        end
        bus.rsp_result = tag_vld_q[LAT-1] ? bus.mult_result : '0;
        bus.rsp_last   = tag_vld_q[LAT-1] && tag_last_q[LAT-1];
        bus.busy       = (state_q == BURST) || (|tag_vld_q);
    end
endmodule
